// File: rtl/sdram_word_bridge_if.sv
// CPU-side request/response and byte-wide SDRAM-side signals of the word bridge.
// The bridge takes the slave view; the CPU/memory environment takes the master view.
interface sdram_word_bridge_if #(
    parameter int ADDR_W = 26
);
    logic              i_req;
    logic [ADDR_W-1:0] i_addr;
    logic              i_we;
    logic              i_wide;
    logic [15:0]       i_wdata;
    logic              o_busy;
    logic              o_done;
    logic              o_error;
    logic [15:0]       o_rdata;
    logic              o_mem_req;
    logic [ADDR_W-1:0] o_mem_address;
    logic              o_mem_we;
    logic [7:0]        o_mem_data;
    logic [7:0]        i_mem_data;
    logic              i_mem_ready;

    modport slave (
        input  i_req, i_addr, i_we, i_wide, i_wdata, i_mem_data, i_mem_ready,
        output o_busy, o_done, o_error, o_rdata,
        output o_mem_req, o_mem_address, o_mem_we, o_mem_data
    );

    modport master (
        output i_req, i_addr, i_we, i_wide, i_wdata, i_mem_data, i_mem_ready,
        input  o_busy, o_done, o_error, o_rdata,
        input  o_mem_req, o_mem_address, o_mem_we, o_mem_data
    );
endinterface

// File: rtl/sdram_word_bridge.sv
// Splits CPU 8/16-bit little-endian accesses into single-byte SDRAM cycles,
// with a per-byte ready timeout so a stalled memory cannot hang the CPU.
module sdram_word_bridge #(
    parameter int ADDR_W  = 26,
    parameter int TIMEOUT = 255
) (
    input logic                i_clock_25_mhz,
    input logic                i_reset_n,
    sdram_word_bridge_if.slave bus
);
    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_LO   = 3'd1;
    localparam logic [2:0] S_GAP  = 3'd2;
    localparam logic [2:0] S_HI   = 3'd3;
    localparam logic [2:0] S_DONE = 3'd4;

    localparam int               CNT_W      = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] WAIT_LIMIT = CNT_W'(TIMEOUT);

    logic [2:0]        state;
    logic [ADDR_W-1:0] addr_q;
    logic              we_q;
    logic              wide_q;
    logic [7:0]        wdata_hi_q;
    logic              first_q;
    logic [CNT_W-1:0]  wait_cnt;
    logic              busy_q;
    logic              error_q;
    logic [15:0]       rdata_q;
    logic              mem_req_q;
    logic              mem_we_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [7:0]        mem_data_q;

    logic              in_byte;
    logic              ready_ok;
    logic              timed_out;
    logic              byte_end;
    logic [7:0]        rx_byte;

    // Ready in the first cycle of a byte may be left over from the previous cycle.
    always_comb begin
        in_byte   = (state == S_LO) || (state == S_HI);
        ready_ok  = in_byte && !first_q && bus.i_mem_ready;
        timed_out = (TIMEOUT != 0) && in_byte && !ready_ok && (wait_cnt == WAIT_LIMIT);
        byte_end  = ready_ok || timed_out;
        rx_byte   = ready_ok ? bus.i_mem_data : 8'hFF;
    end

    always_ff @(posedge i_clock_25_mhz or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state      <= S_IDLE;
            addr_q     <= '0;
            we_q       <= 1'b0;
            wide_q     <= 1'b0;
            wdata_hi_q <= '0;
            first_q    <= 1'b0;
            wait_cnt   <= '0;
            busy_q     <= 1'b0;
            error_q    <= 1'b0;
            rdata_q    <= '0;
            mem_req_q  <= 1'b0;
            mem_we_q   <= 1'b0;
            mem_addr_q <= '0;
            mem_data_q <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.i_req) begin
                        addr_q     <= bus.i_addr;
                        we_q       <= bus.i_we;
                        wide_q     <= bus.i_wide;
                        wdata_hi_q <= bus.i_wdata[15:8];
                        busy_q     <= 1'b1;
                        error_q    <= 1'b0;
                        rdata_q    <= '0;
                        first_q    <= 1'b1;
                        wait_cnt   <= '0;
                        mem_req_q  <= 1'b1;
                        mem_we_q   <= bus.i_we;
                        mem_addr_q <= bus.i_addr;
                        if (bus.i_we) mem_data_q <= bus.i_wdata[7:0];
                        state      <= S_LO;
                    end
                end
                S_LO, S_HI: begin
                    first_q <= 1'b0;
                    if (byte_end) begin
                        mem_req_q <= 1'b0;
                        mem_we_q  <= 1'b0;
                        if (timed_out) error_q <= 1'b1;
                        if (!we_q) begin
                            if (state == S_LO) rdata_q[7:0]  <= rx_byte;
                            else               rdata_q[15:8] <= rx_byte;
                        end
                        state <= (state == S_LO && wide_q) ? S_GAP : S_DONE;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                S_GAP: begin
                    first_q    <= 1'b1;
                    wait_cnt   <= '0;
                    mem_req_q  <= 1'b1;
                    mem_we_q   <= we_q;
                    mem_addr_q <= addr_q + 1'b1;
                    if (we_q) mem_data_q <= wdata_hi_q;
                    state      <= S_HI;
                end
                S_DONE: begin
                    busy_q <= 1'b0;
                    state  <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.o_busy        = busy_q;
    assign bus.o_done        = (state == S_DONE);
    assign bus.o_error       = error_q;
    assign bus.o_rdata       = rdata_q;
    assign bus.o_mem_req     = mem_req_q;
    assign bus.o_mem_address = mem_addr_q;
    assign bus.o_mem_we      = mem_we_q;
    assign bus.o_mem_data    = mem_data_q;
endmodule

// File: tb/tb_sdram_word_bridge.sv
// Bench for sdram_word_bridge: a byte memory with programmable ready delay
// plus a request-level reference model of the expected CPU-visible result.
module tb_sdram_word_bridge;
    localparam int                ADDR_W = 26;
    localparam int                TMO    = 4;
    localparam logic [ADDR_W-1:0] AMAX   = '1;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #20 clk = ~clk;

    sdram_word_bridge_if #(.ADDR_W(ADDR_W)) bus ();

    sdram_word_bridge #(.ADDR_W(ADDR_W), .TIMEOUT(TMO)) dut (
        .i_clock_25_mhz(clk),
        .i_reset_n     (rst_n),
        .bus           (bus)
    );

    int tests = 0;
    int fails = 0;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic              we;
        logic [7:0]        data;
    } op_t;

    logic [7:0] env_mem [int];
    logic [7:0] ref_mem [int];
    op_t        log_q [$];
    int         mem_waits   = 2;
    bit         never_ready = 1'b0;
    bit         stuck_ready = 1'b0;
    int         req_cyc     = 0;

    function automatic logic [7:0] init_byte(input logic [ADDR_W-1:0] a);
        return a[7:0] ^ a[15:8] ^ a[23:16] ^ 8'h5A;
    endfunction

    function automatic logic [7:0] env_rd(input logic [ADDR_W-1:0] a);
        if (env_mem.exists(int'(a))) return env_mem[int'(a)];
        return init_byte(a);
    endfunction

    function automatic logic [7:0] ref_rd(input logic [ADDR_W-1:0] a);
        if (ref_mem.exists(int'(a))) return ref_mem[int'(a)];
        return init_byte(a);
    endfunction

    function automatic logic [54:0] outs();
        return {bus.o_busy, bus.o_done, bus.o_error, bus.o_rdata, bus.o_mem_req,
                bus.o_mem_address, bus.o_mem_we, bus.o_mem_data};
    endfunction

    // Memory: ready appears on the (mem_waits+1)-th cycle of a held strobe.
    always @(negedge clk) begin
        op_t op;
        bus.i_mem_data = env_rd(bus.o_mem_address);
        if (bus.o_mem_req === 1'b1) begin
            req_cyc = req_cyc + 1;
            if (!never_ready && req_cyc == mem_waits + 1) begin
                bus.i_mem_ready = 1'b1;
                op.addr = bus.o_mem_address;
                op.we   = bus.o_mem_we;
                op.data = bus.o_mem_data;
                log_q.push_back(op);
                if (bus.o_mem_we === 1'b1) env_mem[int'(bus.o_mem_address)] = bus.o_mem_data;
            end else begin
                bus.i_mem_ready = stuck_ready;
            end
        end else begin
            req_cyc = 0;
            bus.i_mem_ready = stuck_ready;
        end
    end

    // Request-level expectation: n waits per byte, timeout replaces n by TMO and bytes by FF.
    function automatic void model(input logic [ADDR_W-1:0] a, input logic we, input logic wide,
                                  input logic [15:0] wd, input int n, input bit never,
                                  output int lat, output logic [15:0] rd, output logic err,
                                  output int nops);
        bit                to;
        int                eff;
        logic [ADDR_W-1:0] a1;
        to   = never || (n > TMO);
        eff  = to ? TMO : n;
        a1   = a + 1'b1;
        lat  = wide ? 2 * eff + 5 : eff + 3;
        err  = to;
        nops = to ? 0 : (wide ? 2 : 1);
        rd   = '0;
        if (!we) begin
            rd[7:0] = to ? 8'hFF : ref_rd(a);
            if (wide) rd[15:8] = to ? 8'hFF : ref_rd(a1);
        end else if (!to) begin
            ref_mem[int'(a)] = wd[7:0];
            if (wide) ref_mem[int'(a1)] = wd[15:8];
        end
    endfunction

    task automatic drive_req(input logic [ADDR_W-1:0] a, input logic we, input logic wide,
                             input logic [15:0] wd, output int lat, output logic [15:0] rd,
                             output logic err, output bit busy_ok, output int gap_cyc,
                             output bit we_leak, output bit post_idle);
        bit done;
        log_q.delete();
        @(negedge clk);
        bus.i_req   = 1'b1;
        bus.i_addr  = a;
        bus.i_we    = we;
        bus.i_wide  = wide;
        bus.i_wdata = wd;
        @(posedge clk);
        @(negedge clk);
        bus.i_req = 1'b0;
        lat = 1; rd = '0; err = 1'b0; busy_ok = 1'b1; gap_cyc = 0; we_leak = 1'b0; done = 1'b0;
        for (int c = 0; c < 2000 && !done; c++) begin
            lat++;
            if (bus.o_busy !== 1'b1) busy_ok = 1'b0;
            if (bus.o_mem_req === 1'b0) gap_cyc++;
            if (bus.o_mem_we === 1'b1 && bus.o_mem_req !== 1'b1) we_leak = 1'b1;
            if (bus.o_done === 1'b1) begin
                done = 1'b1;
                rd   = bus.o_rdata;
                err  = bus.o_error;
            end else begin
                @(negedge clk);
            end
        end
        if (!done) lat = -1;
        @(negedge clk);
        post_idle = (bus.o_busy === 1'b0) && (bus.o_done === 1'b0);
    endtask

    task automatic test_reset();
        #3 rst_n = 1'b0;
        #5;
        tests++;
        if (outs() !== '0) begin fails++; $display("FAIL reset_async got %h want 0", outs()); end
        repeat (2) @(posedge clk);
        #1;
        tests++;
        if (outs() !== '0) begin fails++; $display("FAIL reset_held got %h want 0", outs()); end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        tests++;
        if (outs() !== '0) begin fails++; $display("FAIL reset_release got %h want 0", outs()); end
    endtask

    task automatic test_read8();
        int lat, gap; logic [15:0] rd; logic err; bit bok, leak, pidle;
        env_mem[int'(26'h0001234)] = 8'hA5;
        ref_mem[int'(26'h0001234)] = 8'hA5;
        mem_waits = 2;
        drive_req(26'h0001234, 1'b0, 1'b0, 16'h0000, lat, rd, err, bok, gap, leak, pidle);
        tests++; if (rd !== 16'h00A5) begin fails++; $display("FAIL read8_data got %h want 00a5", rd); end
        tests++; if (lat != 5) begin fails++; $display("FAIL read8_latency got %0d want 5", lat); end
        tests++; if (!bok || !pidle || err !== 1'b0) begin
            fails++; $display("FAIL read8_busy_done got busy_ok=%0d idle=%0d err=%0d want 1 1 0", bok, pidle, err);
        end
        tests++; if (log_q.size() != 1 || gap != 1) begin
            fails++; $display("FAIL read8_cycles got ops=%0d gap=%0d want 1 1", log_q.size(), gap);
        end
    endtask

    task automatic test_write16();
        int lat, gap; logic [15:0] rd; logic err; bit bok, leak, pidle;
        op_t e0, e1;
        e0 = {26'h0000010, 1'b1, 8'hEF};
        e1 = {26'h0000011, 1'b1, 8'hBE};
        mem_waits = 1;
        drive_req(26'h0000010, 1'b1, 1'b1, 16'hBEEF, lat, rd, err, bok, gap, leak, pidle);
        tests++; if (log_q.size() != 2) begin
            fails++; $display("FAIL write16_ops got %0d want 2", log_q.size());
        end else begin
            tests++; if (log_q[0] !== e0) begin fails++; $display("FAIL write16_lo got %h want %h", log_q[0], e0); end
            tests++; if (log_q[1] !== e1) begin fails++; $display("FAIL write16_hi got %h want %h", log_q[1], e1); end
        end
        tests++; if (gap != 2 || leak) begin
            fails++; $display("FAIL write16_gap got gap=%0d leak=%0d want 2 0", gap, leak);
        end
        tests++; if (lat != 7 || !pidle || !bok) begin
            fails++; $display("FAIL write16_done got lat=%0d idle=%0d busy_ok=%0d want 7 1 1", lat, pidle, bok);
        end
    endtask

    task automatic test_wrap();
        int lat, gap; logic [15:0] rd; logic err; bit bok, leak, pidle;
        env_mem[int'(AMAX)] = 8'h12; ref_mem[int'(AMAX)] = 8'h12;
        env_mem[0] = 8'h34;          ref_mem[0] = 8'h34;
        mem_waits = 2;
        drive_req(AMAX, 1'b0, 1'b1, 16'h0000, lat, rd, err, bok, gap, leak, pidle);
        tests++; if (rd !== 16'h3412) begin fails++; $display("FAIL wrap_data got %h want 3412", rd); end
        tests++; if (log_q.size() != 2 || log_q[log_q.size()-1].addr !== '0) begin
            fails++; $display("FAIL wrap_addr got ops=%0d want second address 0", log_q.size());
        end
        tests++; if (lat != 9) begin fails++; $display("FAIL wrap_latency got %0d want 9", lat); end
    endtask

    task automatic test_timeout();
        int lat, gap; logic [15:0] rd; logic err; bit bok, leak, pidle;
        never_ready = 1'b1;
        drive_req(26'h0000400, 1'b0, 1'b1, 16'h0000, lat, rd, err, bok, gap, leak, pidle);
        never_ready = 1'b0;
        tests++; if (err !== 1'b1) begin fails++; $display("FAIL timeout_error got %0d want 1", err); end
        tests++; if (rd !== 16'hFFFF) begin fails++; $display("FAIL timeout_data got %h want ffff", rd); end
        tests++; if (lat != 13) begin fails++; $display("FAIL timeout_latency got %0d want 13", lat); end
        mem_waits = 1;
        drive_req(26'h0000401, 1'b0, 1'b0, 16'h0000, lat, rd, err, bok, gap, leak, pidle);
        tests++; if (err !== 1'b0 || rd !== {8'h00, ref_rd(26'h0000401)} || lat != 4) begin
            fails++; $display("FAIL timeout_recover got err=%0d rd=%h lat=%0d want 0 %h 4", err, rd,
                              lat, {8'h00, ref_rd(26'h0000401)});
        end
        mem_waits = TMO;
        drive_req(26'h0000402, 1'b0, 1'b0, 16'h0000, lat, rd, err, bok, gap, leak, pidle);
        tests++; if (err !== 1'b0 || lat != TMO + 3 || rd !== {8'h00, ref_rd(26'h0000402)}) begin
            fails++; $display("FAIL ready_at_limit got err=%0d lat=%0d rd=%h want 0 %0d %h", err, lat,
                              rd, TMO + 3, {8'h00, ref_rd(26'h0000402)});
        end
    endtask

    task automatic test_stale_ready();
        int lat, gap; logic [15:0] rd; logic err; bit bok, leak, pidle;
        logic [15:0] want;
        want = {ref_rd(26'h0000501), ref_rd(26'h0000500)};
        stuck_ready = 1'b1;
        mem_waits   = 1;
        drive_req(26'h0000500, 1'b0, 1'b1, 16'h0000, lat, rd, err, bok, gap, leak, pidle);
        stuck_ready = 1'b0;
        tests++; if (lat != 7) begin fails++; $display("FAIL stale_latency got %0d want 7", lat); end
        tests++; if (rd !== want) begin fails++; $display("FAIL stale_data got %h want %h", rd, want); end
    endtask

    task automatic test_hold_req();
        logic [ADDR_W-1:0] a, b;
        int dones, first_done, second_done;
        logic busy4, busy5;
        a = 26'h0000200; b = 26'h0000300;
        dones = 0; first_done = 0; second_done = 0; busy4 = 1'b1; busy5 = 1'b0;
        log_q.delete();
        mem_waits = 1;
        @(negedge clk);
        bus.i_req = 1'b1; bus.i_addr = a; bus.i_we = 1'b0; bus.i_wide = 1'b0;
        @(posedge clk);
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            if (c == 1) bus.i_addr = b;
            if (bus.o_done === 1'b1) begin
                dones++;
                if (first_done == 0) first_done = c; else second_done = c;
            end
            if (c == 4) busy4 = bus.o_busy;
            if (c == 5) busy5 = bus.o_busy;
            if (c == 7) bus.i_req = 1'b0;
        end
        tests++; if (dones != 2 || first_done != 3 || second_done != 7) begin
            fails++; $display("FAIL hold_dones got n=%0d at %0d,%0d want 2 at 3,7", dones, first_done, second_done);
        end
        tests++; if (busy4 !== 1'b0 || busy5 !== 1'b1) begin
            fails++; $display("FAIL hold_reaccept got busy4=%0d busy5=%0d want 0 1", busy4, busy5);
        end
        tests++; if (log_q.size() != 2 || log_q[0].addr !== a || log_q[log_q.size()-1].addr !== b) begin
            fails++; $display("FAIL hold_ops got %0d ops want 2 (addr %h then %h)", log_q.size(), a, b);
        end
    endtask

    task automatic test_reset_mid();
        int lat, gap, dones; logic [15:0] rd; logic err; bit bok, leak, pidle, seen;
        logic [ADDR_W-1:0] a;
        a = 26'h0000600; dones = 0; seen = 1'b0;
        never_ready = 1'b1;
        @(negedge clk);
        bus.i_req = 1'b1; bus.i_addr = a; bus.i_we = 1'b0; bus.i_wide = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.i_req = 1'b0;
        for (int c = 0; c < 100 && !seen; c++) begin
            if (bus.o_mem_req === 1'b1 && bus.o_mem_address === a + 1'b1) seen = 1'b1;
            else @(negedge clk);
        end
        tests++; if (!seen) begin fails++; $display("FAIL reset_mid_reach_hi got 0 want 1"); end
        @(negedge clk);
        #5 rst_n = 1'b0;
        #1;
        tests++; if (outs() !== '0) begin fails++; $display("FAIL reset_mid_clear got %h want 0", outs()); end
        repeat (2) begin @(negedge clk); if (bus.o_done === 1'b1) dones++; end
        rst_n = 1'b1;
        never_ready = 1'b0;
        repeat (3) begin @(negedge clk); if (bus.o_done === 1'b1 || bus.o_busy === 1'b1) dones++; end
        tests++; if (dones != 0) begin fails++; $display("FAIL reset_mid_no_done got %0d want 0", dones); end
        mem_waits = 2;
        drive_req(26'h0000700, 1'b0, 1'b1, 16'h0000, lat, rd, err, bok, gap, leak, pidle);
        tests++; if (rd !== {ref_rd(26'h0000701), ref_rd(26'h0000700)} || lat != 9 || err !== 1'b0) begin
            fails++; $display("FAIL reset_mid_after got rd=%h lat=%0d err=%0d want %h 9 0", rd, lat, err,
                              {ref_rd(26'h0000701), ref_rd(26'h0000700)});
        end
    endtask

    task automatic test_random();
        int lat, gap, xlat, nops, n; logic [15:0] rd, xrd, wd; logic err, xerr, we, wide;
        bit bok, leak, pidle;
        logic [ADDR_W-1:0] a;
        for (int i = 0; i < 24; i++) begin
            a    = (i % 5 == 4) ? AMAX : ADDR_W'(32'h100 + $urandom_range(0, 7));
            we   = 1'($urandom_range(0, 1));
            wide = 1'($urandom_range(0, 1));
            wd   = 16'($urandom);
            n    = $urandom_range(1, TMO + 1);
            mem_waits = n;
            model(a, we, wide, wd, n, 1'b0, xlat, xrd, xerr, nops);
            drive_req(a, we, wide, wd, lat, rd, err, bok, gap, leak, pidle);
            tests++; if (rd !== xrd || err !== xerr) begin
                fails++; $display("FAIL rand%0d_result got rd=%h err=%0d want %h %0d", i, rd, err, xrd, xerr);
            end
            tests++; if (lat != xlat || !bok || !pidle || leak) begin
                fails++; $display("FAIL rand%0d_timing got lat=%0d busy_ok=%0d idle=%0d leak=%0d want %0d 1 1 0",
                                  i, lat, bok, pidle, leak, xlat);
            end
            tests++; if (log_q.size() != nops) begin
                fails++; $display("FAIL rand%0d_ops got %0d want %0d", i, log_q.size(), nops);
            end else if (nops > 0) begin
                tests++;
                if (log_q[0].addr !== a || log_q[0].we !== we || (we && log_q[0].data !== wd[7:0]) ||
                    (nops == 2 && (log_q[1].addr !== a + 1'b1 || (we && log_q[1].data !== wd[15:8])))) begin
                    fails++; $display("FAIL rand%0d_bytes got addr=%h we=%0d data=%h want addr=%h we=%0d", i,
                                      log_q[0].addr, log_q[0].we, log_q[0].data, a, we);
                end
            end
        end
    endtask

    initial begin
        bus.i_req   = 1'b0;
        bus.i_addr  = '0;
        bus.i_we    = 1'b0;
        bus.i_wide  = 1'b0;
        bus.i_wdata = '0;
        test_reset();
        test_read8();
        test_write16();
        test_wrap();
        test_timeout();
        test_stale_ready();
        test_hold_req();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
